// File: rtl/mode_switch_ctrl_if.sv
// Operand/opcode handshake bundle: per-source inputs towards the selector and
// the single registered operation towards the ALU.
interface mode_switch_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*DATA_W-1:0] src_a;
    logic [NUM_SRC*DATA_W-1:0] src_b;
    logic [NUM_SRC*OP_W-1:0]   src_opcode;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [DATA_W-1:0]         sel_a;
    logic [DATA_W-1:0]         sel_b;
    logic [OP_W-1:0]           sel_opcode;
    logic                      sel_valid;
    logic                      sel_ready;

    modport master (
        input  src_a, src_b, src_opcode, src_valid, sel_ready,
        output src_ready, sel_a, sel_b, sel_opcode, sel_valid
    );

    modport slave (
        output src_a, src_b, src_opcode, src_valid, sel_ready,
        input  src_ready, sel_a, sel_b, sel_opcode, sel_valid
    );
endinterface

// File: rtl/mode_switch_ctrl.sv
// Source selector for the ALU front end: forwards one source through a single
// registered valid/ready stage and drains it before changing sources.
module mode_switch_ctrl #(
    parameter int DATA_W     = 8,
    parameter int OP_W       = 3,
    parameter int NUM_SRC    = 2,
    parameter int RESET_MODE = 0,
    parameter int SEL_W      = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mode_switch_ctrl_if.master   bus,
    input  logic [SEL_W-1:0]     mode_req,
    input  logic                 mode_req_valid,
    output logic [SEL_W-1:0]     active_mode,
    output logic                 switching,
    output logic                 req_err
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  active_q, active_d;
    logic [SEL_W-1:0]  target_q, target_d;
    logic [DATA_W-1:0] sel_a_q, sel_a_d;
    logic [DATA_W-1:0] sel_b_q, sel_b_d;
    logic [OP_W-1:0]   sel_op_q, sel_op_d;
    logic              sel_valid_q, sel_valid_d;
    logic              req_err_q, req_err_d;
    logic              switching_q, switching_d;

    logic               can_load;
    logic               in_run;
    logic               req_in_range;
    logic               transfer;
    logic [NUM_SRC-1:0] src_ready_w;

    always_comb begin
        can_load     = !sel_valid_q || bus.sel_ready;
        in_run       = (state_q == ST_RUN);
        req_in_range = (int'(mode_req) < NUM_SRC);
        transfer     = in_run && bus.src_valid[active_q] && can_load;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready_w[i] = in_run && (int'(active_q) == i) && can_load;
        end
    end

    // Output stage: load on a transfer, otherwise empty once the ALU takes it.
    always_comb begin
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        sel_op_d    = sel_op_q;
        sel_valid_d = sel_valid_q;
        if (transfer) begin
            sel_a_d     = bus.src_a[int'(active_q)*DATA_W +: DATA_W];
            sel_b_d     = bus.src_b[int'(active_q)*DATA_W +: DATA_W];
            sel_op_d    = bus.src_opcode[int'(active_q)*OP_W +: OP_W];
            sel_valid_d = 1'b1;
        end else if (bus.sel_ready) begin
            sel_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        target_d  = target_q;
        req_err_d = mode_req_valid && ((state_q == ST_SWITCH) || !req_in_range);
        case (state_q)
            ST_RUN: begin
                if (mode_req_valid && req_in_range && (mode_req != active_q)) begin
                    target_d = mode_req;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mode_req_valid && req_in_range) begin
                    target_d = mode_req;
                end
                // Drained once the held operation is gone or leaves this cycle.
                if (can_load) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                active_d = target_q;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        switching_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            active_q    <= SEL_W'(RESET_MODE);
            target_q    <= SEL_W'(RESET_MODE);
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            sel_op_q    <= '0;
            sel_valid_q <= 1'b0;
            req_err_q   <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            target_q    <= target_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            sel_op_q    <= sel_op_d;
            sel_valid_q <= sel_valid_d;
            req_err_q   <= req_err_d;
            switching_q <= switching_d;
        end
    end

    assign bus.src_ready  = src_ready_w;
    assign bus.sel_a      = sel_a_q;
    assign bus.sel_b      = sel_b_q;
    assign bus.sel_opcode = sel_op_q;
    assign bus.sel_valid  = sel_valid_q;
    assign active_mode    = active_q;
    assign switching      = switching_q;
    assign req_err        = req_err_q;
endmodule
